// File: rtl/ddram_resp_pkg.sv
// Shared types and constants for the DDRAM responder: FSM state encoding,
// DDRAM port widths and the stall LFSR parameters.
package ddram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_LAT   = 2'd2,
        RD_DATA  = 2'd3
    } state_t;

    localparam int DDRAM_AW  = 29;
    localparam int DDRAM_DW  = 64;
    localparam int DDRAM_BEW = 8;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/ddram_responder_if.sv
// DDRAM port bundle between a client block (master) and the responder (slave).
interface ddram_responder_if;
    import ddram_resp_pkg::*;

    logic                 DDRAM_BUSY;
    logic [7:0]           DDRAM_BURSTCNT;
    logic [DDRAM_AW-1:0]  DDRAM_ADDR;
    logic [DDRAM_DW-1:0]  DDRAM_DOUT;
    logic                 DDRAM_DOUT_READY;
    logic                 DDRAM_RD;
    logic [DDRAM_DW-1:0]  DDRAM_DIN;
    logic [DDRAM_BEW-1:0] DDRAM_BE;
    logic                 DDRAM_WE;

    modport master (
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

    modport slave (
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

endinterface

// File: rtl/ddram_resp_mem.sv
// Backing store: 64-bit words, byte-enabled write port, read port with a
// registered output that only updates when i_re is high (so a fetched word
// can be held while the read pipeline is paused).
module ddram_resp_mem
    import ddram_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DDRAM_BEW-1:0]  i_be,
    input  logic [DDRAM_DW-1:0]   i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DDRAM_DW-1:0]   o_rdata
);

    logic [DDRAM_DW-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DDRAM_DW-1:0] r_rdata;

    // Byte-lane write.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DDRAM_BEW; b++) begin
                if (i_be[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read, held while i_re is low.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ddram_responder.sv
// DDRAM responder: answers DDRAM_RD/DDRAM_WE from an on-chip memory window.
// Optional macro DDRAM_RESP_STALL_EN adds LFSR-driven BUSY stalls and
// read-beat pauses; without it the port never stalls outside a read.
module ddram_responder
    import ddram_resp_pkg::*;
#(
    parameter int                  ADDR_WIDTH = 12,
    parameter logic [DDRAM_AW-1:0] BASE       = 29'h06000000,
    parameter int                  RD_LATENCY = 2
) (
    input  logic               DDRAM_CLK,
    input  logic               reset_n,
    ddram_responder_if.slave   bus,
    output logic               proto_err
);

    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 2);

    state_t                r_state, w_state_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_rdy, w_rdy_nxt;
    logic [DDRAM_DW-1:0]   r_dout, w_dout_nxt;
    logic                  r_err, w_err_nxt;
    logic [ADDR_WIDTH-1:0] r_idx, w_idx_nxt;
    logic [7:0]            r_left, w_left_nxt;
    logic [3:0]            r_lat, w_lat_nxt;
    logic                  r_miss, w_miss_nxt;

    logic                  w_hit;
    logic [ADDR_WIDTH-1:0] w_loc;
    logic [7:0]            w_n;
    logic                  w_stall_nxt;
    logic                  w_emit;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic                  w_re;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [DDRAM_DW-1:0]   w_rdata;

    assign w_hit = (bus.DDRAM_ADDR[DDRAM_AW-1:ADDR_WIDTH] == BASE[DDRAM_AW-1:ADDR_WIDTH]);
    assign w_loc = bus.DDRAM_ADDR[ADDR_WIDTH-1:0];
    assign w_n   = (bus.DDRAM_BURSTCNT == 8'd0) ? 8'd1 : bus.DDRAM_BURSTCNT;

`ifdef DDRAM_RESP_STALL_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    assign w_lfsr_nxt  = lfsr_step(r_lfsr);
    // The stall applies to the cycle after the edge, so BUSY can stay registered.
    assign w_stall_nxt = (w_lfsr_nxt[1:0] == 2'b11);

    // Free-running stall LFSR.
    always_ff @(posedge DDRAM_CLK) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end
`else
    assign w_stall_nxt = 1'b0;
`endif

    // Next-state and next-output logic; r_idx is the write pointer in a write
    // burst and the next-word-to-fetch pointer in a read.
    always_comb begin
        w_state_nxt = r_state;
        w_rdy_nxt   = 1'b0;
        w_dout_nxt  = r_dout;
        w_err_nxt   = r_err;
        w_idx_nxt   = r_idx;
        w_left_nxt  = r_left;
        w_lat_nxt   = r_lat;
        w_miss_nxt  = r_miss;
        w_emit      = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_idx;
        w_re        = 1'b0;
        w_raddr     = r_idx;

        case (r_state)
            IDLE: begin
                if (bus.DDRAM_WE && !r_busy) begin
                    w_we       = w_hit;
                    w_waddr    = w_loc;
                    w_idx_nxt  = w_loc + ADDR_WIDTH'(1);
                    w_left_nxt = w_n - 8'd1;
                    w_miss_nxt = !w_hit;
                    if (!w_hit || bus.DDRAM_RD) begin
                        w_err_nxt = 1'b1;
                    end
                    if (w_n > 8'd1) begin
                        w_state_nxt = WR_BURST;
                    end
                end else if (bus.DDRAM_RD && !r_busy) begin
                    // Fetch the first word now; it is held in the memory
                    // output register until the first beat goes out.
                    w_re        = 1'b1;
                    w_raddr     = w_loc;
                    w_idx_nxt   = w_loc + ADDR_WIDTH'(1);
                    w_left_nxt  = w_n;
                    w_lat_nxt   = LAT_INIT;
                    w_miss_nxt  = !w_hit;
                    w_state_nxt = RD_LAT;
                    if (!w_hit) begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            WR_BURST: begin
                if (!r_busy) begin
                    if (bus.DDRAM_RD) begin
                        w_err_nxt = 1'b1;
                    end
                    if (bus.DDRAM_WE) begin
                        w_we       = !r_miss;
                        w_idx_nxt  = r_idx + ADDR_WIDTH'(1);
                        w_left_nxt = r_left - 8'd1;
                        if (r_left == 8'd1) begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            RD_LAT: begin
                if (r_lat == 4'd0) begin
                    w_emit = !w_stall_nxt;
                end else begin
                    w_lat_nxt = r_lat - 4'd1;
                end
            end
            RD_DATA: begin
                if (r_left == 8'd0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_emit = !w_stall_nxt;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_emit) begin
            w_rdy_nxt   = 1'b1;
            w_dout_nxt  = r_miss ? '0 : w_rdata;
            w_re        = 1'b1;
            w_raddr     = r_idx;
            w_idx_nxt   = r_idx + ADDR_WIDTH'(1);
            w_left_nxt  = r_left - 8'd1;
            w_state_nxt = RD_DATA;
        end

        w_busy_nxt = (w_state_nxt == RD_LAT) || (w_state_nxt == RD_DATA) || w_stall_nxt;
    end

    // State and registered outputs.
    always_ff @(posedge DDRAM_CLK) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b1;
            r_rdy   <= 1'b0;
            r_dout  <= '0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_left  <= '0;
            r_lat   <= '0;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_rdy   <= w_rdy_nxt;
            r_dout  <= w_dout_nxt;
            r_err   <= w_err_nxt;
            r_idx   <= w_idx_nxt;
            r_left  <= w_left_nxt;
            r_lat   <= w_lat_nxt;
            r_miss  <= w_miss_nxt;
        end
    end

    ddram_resp_mem #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .i_clk   (DDRAM_CLK),
        .i_we    (w_we && reset_n),
        .i_waddr (w_waddr),
        .i_be    (bus.DDRAM_BE),
        .i_wdata (bus.DDRAM_DIN),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign bus.DDRAM_BUSY       = r_busy;
    assign bus.DDRAM_DOUT       = r_dout;
    assign bus.DDRAM_DOUT_READY = r_rdy;
    assign proto_err            = r_err;

endmodule
